injector_peak_hold: RTL and testbench
=====================================

# injector_peak_hold

Parametrised peak-and-hold fuel-injector driver for the ECU injector subsystem, generalising the fixed four-channel injector system to `CHANNELS` independent channels. Each channel runs its own controller. On enable it drives the injector fully on until the peak-current comparator trips. It then chops the drive in a phase-staggered fixed-period hold PWM, regulated by the hold-current comparator. Missing peak current is flagged as a latched per-channel fault.

## Interface
- `CHANNELS`, 4: number of injector channels; must be ≥1.
- `PWM_PERIOD`, 64: hold chopping period in clocks; must be divisible by `CHANNELS`.
- `PEAK_TIMEOUT`, 4096: maximum clocks allowed in PEAK before FAULT.
- `SENSE_FILTER`, 2: consecutive synchronised-high samples needed to accept a sense input; must be ≥1.
- `BLANK`, 4: clocks after each hold period start during which `i_holdSense` is ignored; must be less than `PWM_PERIOD`.
- `i_clock` in 1: single system clock.
- `i_reset` in 1: asynchronous, active-high reset.
- `i_enable` in `CHANNELS`: per-channel injection request; synchronous to `i_clock`.
- `i_peakSense` in `CHANNELS`: peak-current comparator outputs; asynchronous.
- `i_holdSense` in `CHANNELS`: hold-current comparator outputs; asynchronous.
- `o_injectorDrive` out `CHANNELS`: registered gate drive.
- `o_inHold` out `CHANNELS`: registered; high while the channel is in HOLD.
- `o_fault` out `CHANNELS`: registered; high while the channel is in FAULT.

## Operation
- **Reset values.** While `i_reset` is high, all outputs are 0, all channels are IDLE, all counters and synchroniser flops are 0, and the phase counter is 0.
- **Sense synchronisation.** Each sense bit passes through a two-flop synchroniser.
- **Sense filtering.** A per-channel filter counter increments on every edge where the synchronised sense is high. It clears when the synchronised sense is low. The sense is accepted on the edge where the counter reaches `SENSE_FILTER`.
- **Phase counter.** A shared phase counter runs free from 0 to `PWM_PERIOD-1` and wraps. Channel k's period start is defined as phase == k·(`PWM_PERIOD`/`CHANNELS`).
- **Per-channel states.** IDLE, PEAK, HOLD, FAULT.
  - IDLE: drive 0. Goes to PEAK on an edge with `i_enable[k]`=1.
  - PEAK: drive 1, filter tracks `i_peakSense`, and the peak timer counts edges in PEAK.
    - Accepted peak sense → HOLD, drive 0.
    - Timer reaching `PEAK_TIMEOUT` → FAULT.
    - If both occur on the same edge, HOLD wins.
  - HOLD: at each channel period start, drive goes to 1, the filter clears, and the blank counter loads `BLANK`. After blanking, an accepted `i_holdSense` sets drive to 0 until the next period start.
  - FAULT: drive 0, `o_fault` 1. Leaves to IDLE only when `i_enable[k]`=0.
- **Enable low.** `i_enable[k]`=0 in any state forces IDLE with drive 0 on that edge, and clears the timer and filter. This has priority over every other transition.
- **Channel independence.** Channels never interact except through the shared phase counter.
- **Counter widths.** Timer is $clog2(`PEAK_TIMEOUT`+1) bits, filter is $clog2(`SENSE_FILTER`+1) bits, blank counter is $clog2(`BLANK`+1) bits, phase counter is $clog2(`PWM_PERIOD`) bits. All counters saturate, with no wrap, except the phase counter.

## Timing
- **Enable to drive.** `i_enable[k]` sampled high at edge N puts the channel in PEAK with `o_injectorDrive[k]`=1 after edge N.
- **Sense latency.** A raw sense high and stable before edge M is accepted at edge M+1+`SENSE_FILTER`. The state and drive change after that same edge; with default parameters that is M+3.
- **Peak timeout.** Entering PEAK at edge N with no accepted peak sense gives FAULT after edge N+`PEAK_TIMEOUT`.
- **Hold period start.** Drive rises after the edge where the phase counter equals the channel offset.
- **Reset.** Reset asserted mid-operation drops all outputs asynchronously, with no clock edge needed. Deassertion is synchronised externally.
- **Disable latency.** Enable low sampled at edge N gives drive 0 after edge N, i.e. one cycle of latency.

## Structure
- **Package `injector_pkg`.** Holds the `inj_state_t` enum (IDLE, PEAK, HOLD, FAULT) and the default parameter constants.
- **Sub-module `injector_channel`.** Contains the synchronisers, filter, timer, blank counter and FSM for one channel. The per-channel phase offset is passed in as a parameter.
- **Top level.** Holds the shared phase counter and a generate loop instantiating `CHANNELS` copies of `injector_channel`.

## Test plan
- **Peak to hold.** Defaults. Enable ch0 at edge 10, raise `i_peakSense[0]` before edge 50 → drive high edges 10–52, `o_inHold[0]`=1 and drive 0 after edge 53.
- **Peak timeout.** `PEAK_TIMEOUT`=100. Enable ch1 at edge 5 with peak sense never asserted → `o_fault[1]`=1 and drive 0 after edge 105. Dropping enable at edge 200 → IDLE after edge 200 and `o_fault[1]`=0.
- **Hold chopping and staggering.** All channels in HOLD with `i_holdSense` held high → each channel's drive pulses high for exactly `BLANK`+1+`SENSE_FILTER` clocks per 64-clock period. Pulse starts are offset by 0, 16, 32 and 48 clocks.
- **Sense glitch rejection.** 1-cycle pulses on `i_peakSense` every 3 clocks → channel stays in PEAK and reaches FAULT at the timeout.
- **Simultaneous peak accept and timeout.** Peak sense accepted on exactly edge N+`PEAK_TIMEOUT` → HOLD, no fault.
- **Reset mid-operation.** Assert `i_reset` mid-HOLD between clock edges → all drives 0 immediately. After release and re-enable, the full PEAK sequence restarts from phase 0.

Source files
------------

// File: rtl/injector_pkg.sv
// Shared types and default constants for the peak-and-hold injector driver.
package injector_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PEAK  = 2'd1,
    HOLD  = 2'd2,
    FAULT = 2'd3
  } inj_state_t;

  localparam int DEF_CHANNELS     = 4;
  localparam int DEF_PWM_PERIOD   = 64;
  localparam int DEF_PEAK_TIMEOUT = 4096;
  localparam int DEF_SENSE_FILTER = 2;
  localparam int DEF_BLANK        = 4;

  // Bits needed to index max_val distinct values, never less than one.
  function automatic int cnt_width(input int max_val);
    return (max_val > 1) ? $clog2(max_val) : 1;
  endfunction

endpackage

// File: rtl/injector_channel.sv
// One injector channel: sense synchronisers, filter, peak timer, blanking and
// the IDLE/PEAK/HOLD/FAULT controller.
module injector_channel
  import injector_pkg::*;
#(
  parameter int PEAK_TIMEOUT = DEF_PEAK_TIMEOUT,
  parameter int SENSE_FILTER = DEF_SENSE_FILTER,
  parameter int BLANK        = DEF_BLANK,
  parameter int PHASE_W      = 6,
  parameter int PHASE_OFFSET = 0
) (
  input  logic               i_clock,
  input  logic               i_reset,
  input  logic               i_enable,
  input  logic               i_peakSense,
  input  logic               i_holdSense,
  input  logic [PHASE_W-1:0] i_phase,
  output logic               o_injectorDrive,
  output logic               o_inHold,
  output logic               o_fault
);

  localparam int TIMER_W = cnt_width(PEAK_TIMEOUT + 1);
  localparam int FILT_W  = cnt_width(SENSE_FILTER + 1);
  localparam int BLANK_W = cnt_width(BLANK + 1);

  localparam logic [TIMER_W-1:0] TIMER_MAX  = TIMER_W'(PEAK_TIMEOUT);
  localparam logic [FILT_W-1:0]  FILT_MAX   = FILT_W'(SENSE_FILTER);
  localparam logic [BLANK_W-1:0] BLANK_LOAD = BLANK_W'(BLANK);
  localparam logic [PHASE_W-1:0] OFFSET     = PHASE_W'(PHASE_OFFSET);

  logic               r_peak_sync1, r_peak_sync2;
  logic               r_hold_sync1, r_hold_sync2;
  inj_state_t         r_state, w_state_next;
  logic               r_drive, w_drive_next;
  logic               r_in_hold, r_fault;
  logic [TIMER_W-1:0] r_timer, w_timer_next, w_timer_inc;
  logic [FILT_W-1:0]  r_filter, w_filter_next, w_filter_inc;
  logic [BLANK_W-1:0] r_blank, w_blank_next;

  logic w_blank_idle, w_sense, w_accept, w_timeout, w_period_start;

  assign w_blank_idle   = (r_blank == '0);
  assign w_period_start = (i_phase == OFFSET);
  assign w_sense        = (r_state == PEAK) ? r_peak_sync2 : r_hold_sync2;
  assign w_filter_inc   = (r_filter == FILT_MAX) ? FILT_MAX : r_filter + 1'b1;
  assign w_timer_inc    = (r_timer == TIMER_MAX) ? TIMER_MAX : r_timer + 1'b1;
  assign w_accept       = w_sense && (w_filter_inc == FILT_MAX);
  assign w_timeout      = (w_timer_inc == TIMER_MAX);

  // Hold sense is masked at the second stage while blanking, so the filter
  // sees the end of blanking exactly like a fresh comparator rising edge.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_peak_sync1 <= 1'b0;
      r_peak_sync2 <= 1'b0;
      r_hold_sync1 <= 1'b0;
      r_hold_sync2 <= 1'b0;
    end else begin
      r_peak_sync1 <= i_peakSense;
      r_peak_sync2 <= r_peak_sync1;
      r_hold_sync1 <= i_holdSense;
      r_hold_sync2 <= r_hold_sync1 & w_blank_idle;
    end
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_state   <= IDLE;
      r_drive   <= 1'b0;
      r_in_hold <= 1'b0;
      r_fault   <= 1'b0;
      r_timer   <= '0;
      r_filter  <= '0;
      r_blank   <= '0;
    end else begin
      r_state   <= w_state_next;
      r_drive   <= w_drive_next;
      r_in_hold <= (w_state_next == HOLD);
      r_fault   <= (w_state_next == FAULT);
      r_timer   <= w_timer_next;
      r_filter  <= w_filter_next;
      r_blank   <= w_blank_next;
    end
  end

  always_comb begin
    w_state_next  = r_state;
    w_drive_next  = r_drive;
    w_timer_next  = r_timer;
    w_filter_next = r_filter;
    w_blank_next  = r_blank;
    case (r_state)
      IDLE: begin
        w_drive_next  = 1'b0;
        w_timer_next  = '0;
        w_filter_next = '0;
        w_blank_next  = '0;
        if (i_enable) begin
          w_state_next = PEAK;
          w_drive_next = 1'b1;
        end
      end
      PEAK: begin
        w_drive_next  = 1'b1;
        w_timer_next  = w_timer_inc;
        w_filter_next = w_sense ? w_filter_inc : '0;
        // Accepting peak current beats a timeout landing on the same edge.
        if (w_accept) begin
          w_state_next  = HOLD;
          w_drive_next  = 1'b0;
          w_filter_next = '0;
        end else if (w_timeout) begin
          w_state_next = FAULT;
          w_drive_next = 1'b0;
        end
      end
      HOLD: begin
        if (w_period_start) begin
          w_drive_next  = 1'b1;
          w_filter_next = '0;
          w_blank_next  = BLANK_LOAD;
        end else if (!w_blank_idle) begin
          w_blank_next  = r_blank - 1'b1;
          w_filter_next = '0;
        end else begin
          w_filter_next = w_sense ? w_filter_inc : '0;
          if (w_accept) begin
            w_drive_next = 1'b0;
          end
        end
      end
      FAULT: begin
        w_drive_next = 1'b0;
      end
      default: begin
        w_state_next = IDLE;
        w_drive_next = 1'b0;
      end
    endcase
    if (!i_enable) begin
      w_state_next  = IDLE;
      w_drive_next  = 1'b0;
      w_timer_next  = '0;
      w_filter_next = '0;
      w_blank_next  = '0;
    end
  end

  assign o_injectorDrive = r_drive;
  assign o_inHold        = r_in_hold;
  assign o_fault         = r_fault;

endmodule

// File: rtl/injector_peak_hold.sv
// Multi-channel peak-and-hold injector driver: a shared free-running hold
// phase counter and one independent controller per channel.
module injector_peak_hold
  import injector_pkg::*;
#(
  parameter int CHANNELS     = DEF_CHANNELS,
  parameter int PWM_PERIOD   = DEF_PWM_PERIOD,
  parameter int PEAK_TIMEOUT = DEF_PEAK_TIMEOUT,
  parameter int SENSE_FILTER = DEF_SENSE_FILTER,
  parameter int BLANK        = DEF_BLANK
) (
  input  logic                i_clock,
  input  logic                i_reset,
  input  logic [CHANNELS-1:0] i_enable,
  input  logic [CHANNELS-1:0] i_peakSense,
  input  logic [CHANNELS-1:0] i_holdSense,
  output logic [CHANNELS-1:0] o_injectorDrive,
  output logic [CHANNELS-1:0] o_inHold,
  output logic [CHANNELS-1:0] o_fault
);

  localparam int                 PHASE_W    = cnt_width(PWM_PERIOD);
  localparam int                 SLOT       = PWM_PERIOD / CHANNELS;
  localparam logic [PHASE_W-1:0] PHASE_LAST = PHASE_W'(PWM_PERIOD - 1);

  logic [PHASE_W-1:0] r_phase;

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_phase <= '0;
    end else if (r_phase == PHASE_LAST) begin
      r_phase <= '0;
    end else begin
      r_phase <= r_phase + 1'b1;
    end
  end

  // Channel gi starts its hold period gi slots into the shared phase.
  generate
    for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_chan
      injector_channel #(
        .PEAK_TIMEOUT (PEAK_TIMEOUT),
        .SENSE_FILTER (SENSE_FILTER),
        .BLANK        (BLANK),
        .PHASE_W      (PHASE_W),
        .PHASE_OFFSET (gi * SLOT)
      ) u_chan (
        .i_clock         (i_clock),
        .i_reset         (i_reset),
        .i_enable        (i_enable[gi]),
        .i_peakSense     (i_peakSense[gi]),
        .i_holdSense     (i_holdSense[gi]),
        .i_phase         (r_phase),
        .o_injectorDrive (o_injectorDrive[gi]),
        .o_inHold        (o_inHold[gi]),
        .o_fault         (o_fault[gi])
      );
    end
  endgenerate

endmodule

// File: tb/tb_injector_peak_hold.sv
// Directed bench: expectations are queued with the edge at which they must
// hold and are checked 1 ns after that edge.
module tb_injector_peak_hold;

  localparam int CH = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [CH-1:0] en, pk, hd;
  logic [CH-1:0] drv, inh, flt;

  always #5 clk = ~clk;

  injector_peak_hold #(
    .CHANNELS     (CH),
    .PWM_PERIOD   (64),
    .PEAK_TIMEOUT (100),
    .SENSE_FILTER (2),
    .BLANK        (4)
  ) dut (
    .i_clock         (clk),
    .i_reset         (rst),
    .i_enable        (en),
    .i_peakSense     (pk),
    .i_holdSense     (hd),
    .o_injectorDrive (drv),
    .o_inHold        (inh),
    .o_fault         (flt)
  );

  typedef struct {
    int    due;
    int    sig;
    int    ch;
    logic  val;
    string tag;
  } exp_t;

  exp_t sb[$];
  int   cyc;
  int   n_tests = 0;
  int   n_fail  = 0;

  function automatic logic obs_bit(input int sig, input int ch);
    case (sig)
      0:       return drv[ch];
      1:       return inh[ch];
      default: return flt[ch];
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp)
      $display("[TB] %s observed %0h expected %0h", tag, obs, exp);
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic expect_at(input int due, input int sig, input int ch, input logic val, input string tag);
    exp_t e;
    e.due = due;
    e.sig = sig;
    e.ch  = ch;
    e.val = val;
    e.tag = tag;
    sb.push_back(e);
  endtask

  task automatic step();
    int i;
    @(posedge clk);
    #1;
    cyc++;
    i = 0;
    while (i < sb.size()) begin
      if (sb[i].due == cyc) begin
        check($sformatf("%s@%0d", sb[i].tag, cyc),
              32'(obs_bit(sb[i].sig, sb[i].ch)), 32'(sb[i].val));
        sb.delete(i);
      end else begin
        i++;
      end
    end
  endtask

  task automatic run_to(input int target);
    while (cyc < target) step();
  endtask

  initial begin
    rst = 1'b1;
    en  = '0;
    pk  = '0;
    hd  = '0;
    cyc = 0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_drive", 32'(drv), 32'd0);
    check("reset_inhold", 32'(inh), 32'd0);
    check("reset_fault", 32'(flt), 32'd0);
    rst = 1'b0;
    cyc = 0;

    // Peak to hold on channel 0
    expect_at(9,  0, 0, 1'b0, "idle_drive0");
    expect_at(10, 0, 0, 1'b1, "peak_drive0");
    expect_at(52, 0, 0, 1'b1, "peak_drive0_last");
    expect_at(52, 1, 0, 1'b0, "peak_not_hold0");
    expect_at(53, 1, 0, 1'b1, "hold0");
    expect_at(53, 0, 0, 1'b0, "hold_drive0_off");
    expect_at(64, 0, 0, 1'b0, "hold_drive0_pre_start");
    expect_at(65, 0, 0, 1'b1, "hold_drive0_start");
    run_to(9);  en[0] = 1'b1;
    run_to(49); pk[0] = 1'b1;
    run_to(53); pk[0] = 1'b0;

    // Peak timeout on channel 1, then disable
    expect_at(70,  0, 1, 1'b1, "peak_drive1");
    expect_at(169, 0, 1, 1'b1, "pre_timeout_drive1");
    expect_at(169, 2, 1, 1'b0, "pre_timeout_fault1");
    expect_at(170, 2, 1, 1'b1, "timeout_fault1");
    expect_at(170, 0, 1, 1'b0, "timeout_drive1");
    expect_at(199, 2, 1, 1'b1, "fault1_latched");
    expect_at(200, 2, 1, 1'b0, "disable_fault1");
    expect_at(200, 0, 1, 1'b0, "disable_drive1");
    run_to(69);  en[1] = 1'b1;
    run_to(199); en[1] = 1'b0;

    // Glitchy peak sense on channel 2 never qualifies
    expect_at(210, 0, 2, 1'b1, "glitch_drive2");
    expect_at(309, 2, 2, 1'b0, "glitch_pre_fault2");
    expect_at(309, 0, 2, 1'b1, "glitch_pre_drive2");
    expect_at(310, 2, 2, 1'b1, "glitch_fault2");
    expect_at(310, 1, 2, 1'b0, "glitch_not_hold2");
    run_to(209); en[2] = 1'b1;
    while (cyc < 312) begin
      step();
      pk[2] = (cyc % 3 == 0);
    end
    pk[2] = 1'b0;

    // Channel 3: peak accepted on exactly the timeout edge
    expect_at(439, 0, 3, 1'b1, "tie_pre_drive3");
    expect_at(439, 1, 3, 1'b0, "tie_pre_hold3");
    expect_at(440, 1, 3, 1'b1, "tie_hold3");
    expect_at(440, 2, 3, 1'b0, "tie_no_fault3");
    expect_at(440, 0, 3, 1'b0, "tie_drive3");
    run_to(339); en[3] = 1'b1;
    run_to(436); pk[3] = 1'b1;

    // Bring every channel into HOLD, then chop with hold sense held high
    expect_at(450, 2, 2, 1'b0, "disable_fault2");
    run_to(449); en[2] = 1'b0;
    run_to(459); en[1] = 1'b1; en[2] = 1'b1; pk[1] = 1'b1; pk[2] = 1'b1;
    run_to(470); hd = '1;
    for (int k = 0; k < CH; k++) begin
      expect_at(512 + 16 * k, 0, k, 1'b0, $sformatf("chop_pre%0d", k));
      expect_at(513 + 16 * k, 0, k, 1'b1, $sformatf("chop_start%0d", k));
      expect_at(519 + 16 * k, 0, k, 1'b1, $sformatf("chop_last%0d", k));
      expect_at(520 + 16 * k, 0, k, 1'b0, $sformatf("chop_end%0d", k));
      expect_at(610, 1, k, 1'b1, $sformatf("all_hold%0d", k));
    end
    expect_at(610, 0, 2, 1'b1, "pre_reset_drive2");
    run_to(610);

    // Asynchronous reset between clock edges
    #3 rst = 1'b1;
    #1;
    check("async_reset_drive", 32'(drv), 32'd0);
    check("async_reset_inhold", 32'(inh), 32'd0);
    check("async_reset_fault", 32'(flt), 32'd0);
    step();
    step();
    check("held_reset_drive", 32'(drv), 32'd0);
    en  = '0;
    pk  = '0;
    hd  = '0;
    rst = 1'b0;
    cyc = 0;

    // Full restart with phase counter back at 0
    expect_at(9,  0, 0, 1'b0, "restart_idle0");
    expect_at(10, 0, 0, 1'b1, "restart_peak0");
    expect_at(22, 1, 0, 1'b0, "restart_not_hold0");
    expect_at(23, 1, 0, 1'b1, "restart_hold0");
    expect_at(23, 0, 0, 1'b0, "restart_drive0_off");
    expect_at(64, 0, 0, 1'b0, "restart_pre_start0");
    expect_at(65, 0, 0, 1'b1, "restart_start0");
    expect_at(65, 0, 1, 1'b0, "restart_idle1");
    run_to(9);  en[0] = 1'b1;
    run_to(19); pk[0] = 1'b1;
    run_to(70);

    check("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
